// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock-enable generator: per-channel period/high-time
// with shadowed config that is applied only at period boundaries.
module prog_clk_div #(
    parameter int          NUM_CH  = 2,
    parameter int          CNT_W   = 26,
    parameter int unsigned DEF_DIV = 2**26 - 1,
    parameter int unsigned DEF_HI  = 2**25,
    localparam int         CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_hi,
    output logic [NUM_CH-1:0] cfg_busy,
    output logic [NUM_CH-1:0] CLK_out,
    output logic [NUM_CH-1:0] tick
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] phase_q, phase_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] hi_q, hi_d;
        logic [CNT_W-1:0] sdiv_q, sdiv_d;
        logic [CNT_W-1:0] shi_q, shi_d;
        logic             busy_q, busy_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             wrap;

        // Out-of-range channel numbers never match any generated index.
        assign wr_hit = cfg_we && (int'(cfg_ch) == i);
        assign wrap   = (phase_q == div_q);

        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            div_d   = div_q;
            hi_d    = hi_q;
            sdiv_d  = sdiv_q;
            shi_d   = shi_q;
            busy_d  = busy_q;

            case (state_q)
                ST_STOP: begin
                    // A direct write while stopped supersedes anything still pending.
                    if (wr_hit) begin
                        div_d  = cfg_div;
                        hi_d   = cfg_hi;
                        busy_d = 1'b0;
                    end else if (en[i] && busy_q) begin
                        div_d  = sdiv_q;
                        hi_d   = shi_q;
                        busy_d = 1'b0;
                    end
                    if (en[i]) begin
                        state_d = ST_RUN;
                        phase_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!en[i]) begin
                        state_d = ST_STOP;
                    end else if (wrap) begin
                        phase_d = '0;
                        if (busy_q) begin
                            div_d  = sdiv_q;
                            hi_d   = shi_q;
                            busy_d = 1'b0;
                        end
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                    // Applied above from the old shadow; a same-edge write re-arms it.
                    if (wr_hit) begin
                        sdiv_d = cfg_div;
                        shi_d  = cfg_hi;
                        busy_d = 1'b1;
                    end
                end
                default: state_d = ST_STOP;
            endcase

            clk_d  = (state_d == ST_RUN) && (phase_d < hi_d);
            tick_d = (state_d == ST_RUN) && (phase_d == '0);
        end

        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_STOP;
                phase_q <= '0;
                div_q   <= CNT_W'(DEF_DIV);
                hi_q    <= CNT_W'(DEF_HI);
                sdiv_q  <= '0;
                shi_q   <= '0;
                busy_q  <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                div_q   <= div_d;
                hi_q    <= hi_d;
                sdiv_q  <= sdiv_d;
                shi_q   <= shi_d;
                busy_q  <= busy_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign cfg_busy[i] = busy_q;
        assign CLK_out[i]  = clk_q;
        assign tick[i]     = tick_q;
    end

endmodule
